// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants and return-stack op encoding.
package cpu_pkg;

    localparam int RA_WIDTH = 10;
    localparam int RS_DEPTH = 16;

    // Encoding is {pop, push} so the strobes cast directly onto it.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_REPL = 2'b11
    } stack_op_e;

endpackage

// File: rtl/ret_stack_ram.sv
// ret_stack_ram: backing store below TOS, sync write / async read.
module ret_stack_ram #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 15,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/ret_stack_ctrl.sv
// ret_stack_ctrl: return-address stack with registered TOS, count and sticky
// overflow/underflow flags; older entries live in ret_stack_ram.
module ret_stack_ctrl
    import cpu_pkg::*;
#(
    parameter int WIDTH = RA_WIDTH,
    parameter int DEPTH = RS_DEPTH,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic [PTR_W:0]   count,
    output logic             ovf,
    output logic             unf
);

    localparam int CW = PTR_W + 1;

    logic [WIDTH-1:0] tos_q, tos_d, rdata;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             we, ovf_set, unf_set;
    logic [PTR_W-1:0] lo, waddr, raddr;
    stack_op_e        op;

    assign op    = stack_op_e'({pop, push});
    assign empty = count_q == '0;
    assign full  = count_q == CW'(DEPTH);
    // Modulo arithmetic on the low bits still yields DEPTH-2 when full.
    assign lo    = count_q[PTR_W-1:0];
    assign waddr = lo - PTR_W'(1);
    assign raddr = lo - PTR_W'(2);

    always_comb begin
        tos_d   = tos_q;
        count_d = count_q;
        we      = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case (op)
            OP_PUSH: begin
                if (full) ovf_set = 1'b1;
                else begin
                    we      = !empty;
                    tos_d   = data_in;
                    count_d = count_q + CW'(1);
                end
            end
            OP_POP: begin
                if (empty) unf_set = 1'b1;
                else begin
                    if (count_q > CW'(1)) tos_d = rdata;
                    count_d = count_q - CW'(1);
                end
            end
            OP_REPL: begin
                tos_d = data_in;
                if (empty) begin
                    count_d = CW'(1);
                    unf_set = 1'b1;
                end
            end
            default: ;
        endcase
        ovf_d = (ovf_q & ~clr_err) | ovf_set;
        unf_d = (unf_q & ~clr_err) | unf_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tos_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            tos_q   <= tos_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    ret_stack_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH - 1),
        .AW   (PTR_W)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(waddr),
        .wdata(tos_q),
        .raddr(raddr),
        .rdata(rdata)
    );

    assign data_out = tos_q;
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;

endmodule

// File: tb/tb_ret_stack_ctrl.sv
// tb_ret_stack_ctrl: scoreboard bench; a queue-based LIFO model predicts the
// stack state, a negedge monitor compares whatever is due that cycle.
module tb_ret_stack_ctrl;
    import cpu_pkg::*;

    localparam int W = RA_WIDTH;
    localparam int D = RS_DEPTH;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         push = 1'b0, pop = 1'b0, clr_err = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] data_out;
    logic         empty, full, ovf, unf;
    logic [P:0]   count;

    ret_stack_ctrl #(.WIDTH(W), .DEPTH(D), .PTR_W(P)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
        .clr_err(clr_err), .data_out(data_out), .empty(empty), .full(full),
        .count(count), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        bit           popchk;
        logic [W-1:0] tos;
        bit           tos_k;
        int           cnt;
        bit           o;
        bit           u;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;

    logic [W-1:0] stk[$];
    bit           mo, mu, mk;
    logic [W-1:0] mt;

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.popchk) begin
                if (data_out !== e.tos) begin
                    errors++;
                    $display("FAIL popval cyc=%0d got %h want %h", cyc, data_out, e.tos);
                end
            end else if ((e.tos_k && data_out !== e.tos) || count !== (P+1)'(e.cnt) ||
                         empty !== (e.cnt == 0) || full !== (e.cnt == D) ||
                         ovf !== e.o || unf !== e.u) begin
                errors++;
                $display("FAIL state cyc=%0d got tos=%h cnt=%0d e=%b f=%b o=%b u=%b want tos=%h(known=%0b) cnt=%0d o=%b u=%b",
                         cyc, data_out, count, empty, full, ovf, unf, e.tos, e.tos_k, e.cnt, e.o, e.u);
            end
        end
    end

    task automatic model_reset();
        stk.delete();
        mo = 0; mu = 0; mt = '0; mk = 1;
    endtask

    task automatic op(input bit pu, input bit po, input logic [W-1:0] d, input bit c);
        int n;
        bit so, su;
        @(posedge clk); #1;
        push = pu; pop = po; data_in = d; clr_err = c;
        n = stk.size();
        so = 0; su = 0;
        if (po && !pu && n > 0) sb.push_back('{cyc, 1'b1, stk[n-1], 1'b1, 0, 1'b0, 1'b0});
        if (pu && !po) begin
            if (n == D) so = 1; else stk.push_back(d);
        end else if (po && !pu) begin
            if (n == 0) su = 1;
            else begin
                void'(stk.pop_back());
                if (stk.size() == 0) mk = 0;
            end
        end else if (pu && po) begin
            if (n == 0) begin stk.push_back(d); su = 1; end
            else stk[n-1] = d;
        end
        mo = (mo && !c) || so;
        mu = (mu && !c) || su;
        if (stk.size() > 0) begin mt = stk[stk.size()-1]; mk = 1; end
        sb.push_back('{cyc + 1, 1'b0, mt, mk, stk.size(), mo, mu});
    endtask

    task automatic async_reset();
        @(posedge clk); #1;
        push = 0; pop = 0; clr_err = 0;
        @(negedge clk); #2;
        reset = 1;
        #1;
        checks++;
        if (count !== '0 || data_out !== '0 || empty !== 1'b1 || full !== 1'b0 ||
            ovf !== 1'b0 || unf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got cnt=%0d tos=%h e=%b f=%b o=%b u=%b want all zero, empty=1",
                     count, data_out, empty, full, ovf, unf);
        end
        model_reset();
        @(posedge clk); #2;
        reset = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset = 0;
        op(0, 0, 0, 0);
        op(0, 0, 0, 0);
        op(1, 0, 10'h005, 0);
        op(1, 0, 10'h00A, 0);
        op(1, 0, 10'h3FF, 0);
        repeat (3) op(0, 1, 0, 0);
        op(0, 0, 0, 0);
        for (int i = 0; i < 16; i++) op(1, 0, W'(10'h100 + i), 0);
        op(1, 0, 10'h200, 0);
        repeat (16) op(0, 1, 0, 0);
        op(0, 0, 0, 0);
        op(0, 1, 0, 0);
        op(0, 1, 0, 1);
        op(0, 0, 0, 1);
        op(0, 0, 0, 0);
        op(1, 0, 10'h011, 0);
        op(1, 1, 10'h022, 0);
        op(0, 1, 0, 0);
        op(1, 1, 10'h033, 0);
        op(0, 1, 0, 0);
        op(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) op(1, 0, W'(10'h050 + i), 0);
        async_reset();
        op(1, 0, 10'h044, 0);
        op(0, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            int r, bias;
            bias = ((i / 100) % 2 == 0) ? 65 : 35;
            r = $urandom_range(0, 99);
            op(r < bias, (r >= bias - 10) && (r < 90), W'($urandom), $urandom_range(0, 19) == 0);
        end
        op(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ret_stack_ctrl.md
Name: ret_stack_ctrl

Overview:
- Hardware return-address stack controller driven by the push/pop/s_stack strobes from the monocycle CPU control unit.
- Holds subroutine return PCs in LIFO order.
- The top-of-stack (TOS) is always presented combinationally-stable from a register, so the PC mux can select it in the same cycle the pop strobe is asserted.
- Detects and flags overflow and underflow with sticky error bits.

Parameters:
- WIDTH, 10, bit width of a stored return address (PC width).
- DEPTH, 16, number of entries including TOS; must be a power of two, minimum 2.
- PTR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- push  in  1  push data_in onto the stack this cycle
- pop  in  1  pop TOS this cycle
- data_in  in  WIDTH  return address to push (PC+1 from datapath)
- clr_err  in  1  synchronous clear of sticky ovf/unf
- data_out  out  WIDTH  current TOS value, registered
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- count  out  PTR_W+1  number of valid entries
- ovf  out  1  sticky: push attempted while full (without pop)
- unf  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, active-high): tos=0, count=0, ovf=0, unf=0.
  - empty=1, full=0, data_out=0.
  - Backing array is not reset.
- Storage: TOS register plus backing array of DEPTH-1 entries indexed by sp = count-1 (next-below-TOS slot).
- data_out = TOS register; no combinational path from push/pop/data_in to data_out.
- Push only (push=1, pop=0):
  - Not full: array[count-1] <= tos (only if count>0); tos <= data_in; count+1.
  - Full: no state change except ovf <= 1.
- Pop only (push=0, pop=1):
  - count>1: tos <= array[count-2]; count-1.
  - count==1: tos unchanged (stale value, don't-care); count <= 0.
  - Empty: no state change except unf <= 1.
  - The value popped is data_out as seen during the pop cycle (zero latency for the PC mux).
- Push and pop together (replace):
  - Non-empty, including full: tos <= data_in; count and array unchanged; no flags.
  - Empty: treated as push; tos <= data_in; count <= 1; unf <= 1.
- Neither: hold.
- clr_err=1 clears ovf/unf next edge; if a new error occurs the same cycle, set wins.
- Flags are derived combinationally from the registered count: empty = (count==0), full = (count==DEPTH).
- count never exceeds DEPTH and never wraps below 0.
- Reset asserted mid-operation aborts any in-flight update; state returns to reset values immediately.
- Single-cycle operation; no stalls; one push or pop accepted every cycle.

Decomposition:
- Shared package cpu_pkg:
  - RA_WIDTH (=10) and RS_DEPTH (=16) constants.
  - Stack op encoding constants (OP_NONE, OP_PUSH, OP_POP, OP_REPL) for bench/checker use.
- Sub-module ret_stack_ram: DEPTH-1 x WIDTH array with synchronous write (we, waddr, wdata) and asynchronous read (raddr, rdata).
- ret_stack_ctrl owns TOS, count, and flags, and generates the RAM addresses.

Test Plan:
- Reset then idle -> data_out=0, count=0, empty=1, full=0, ovf=unf=0.
- Push 0x005, 0x00A, 0x3FF on consecutive cycles -> count=3, data_out=0x3FF.
  - Then pop x3 -> data_out reads 0x3FF, 0x00A, 0x005 in each pop cycle; afterwards empty=1, unf=0.
- Push 16 values 0x100..0x10F -> full=1, count=16.
  - 17th push of 0x200 -> ovf=1, data_out still 0x10F, count=16.
  - Pop x16 -> values 0x10F down to 0x100 returned in order.
- Pop while empty -> unf=1, count=0.
  - clr_err same cycle as a second empty pop -> unf stays 1.
  - clr_err alone next cycle -> unf=0.
- Push 0x011 then push+pop with data_in 0x022 -> count=1, data_out=0x022.
  - push+pop on empty with 0x033 -> count=1, data_out=0x033, unf=1.
- Fill to count=5, assert reset asynchronously between clock edges -> count, data_out, and flags reach 0 before the next rising edge.
  - Subsequent push of 0x044 -> count=1, data_out=0x044.
